// File: rtl/gauss3x3_filter_if.sv
// Column-slice streaming bus for the 3x3 Gaussian filter.
// The source drives the pixel triples; the filter drives the blurred pixels.
interface gauss3x3_filter_if;
  logic [10:0]      hcount_in;
  logic [9:0]       vcount_in;
  logic [2:0][15:0] pixels_in;
  logic             data_valid_in;
  logic [15:0]      pixel_data_out;
  logic [10:0]      hcount_out;
  logic [9:0]       vcount_out;
  logic             data_valid_out;

  modport master (
    output hcount_in, vcount_in,
    output pixels_in, data_valid_in,
    input  pixel_data_out, hcount_out,
    input  vcount_out, data_valid_out
  );

  modport slave (
    input  hcount_in, vcount_in,
    input  pixels_in, data_valid_in,
    output pixel_data_out, hcount_out,
    output vcount_out, data_valid_out
  );
endinterface

// File: rtl/gauss3x3_filter.sv
// 3x3 Gaussian blur ([1 2 1;2 4 2;1 2 1]/16) on RGB565 column slices.
// Edge pixels are replicated; a row-end flush emits the last column.
module gauss3x3_filter #(
  parameter int HRES = 1280,
  parameter int VRES = 720
) (
  input  logic clk_in,
  input  logic rst_in,
  gauss3x3_filter_if.slave bus
);
  typedef logic [2:0][15:0] col_t;
  typedef enum logic [1:0] {IDLE, IN_ROW, FLUSH} state_t;

  localparam logic [10:0] HLAST = 11'(HRES - 1);
  localparam logic [9:0]  VLAST = 10'(VRES - 1);

  state_t      r_state;
  col_t        r_c0, r_c1, r_c2;
  col_t        r_fl_l, r_fl_c;
  logic        r_pv, r_fv;
  logic [10:0] r_ph;
  logic [9:0]  r_pvc, r_rowv, r_fvc;
  logic [15:0] r_pix;
  logic [10:0] r_hout;
  logic [9:0]  r_vout;
  logic        r_vld;

  col_t        w_col;
  col_t        w_l, w_c, w_r;
  logic        w_first, w_load, w_emit;
  logic [15:0] w_blur;

  function automatic logic [15:0] blur(
    input col_t l, input col_t c, input col_t r
  );
    col_t        w [3];
    logic [8:0]  sr, sb;
    logic [9:0]  sg;
    logic [31:0] wt;
    w[0] = l;
    w[1] = c;
    w[2] = r;
    sr = 9'd8;
    sg = 10'd8;
    sb = 9'd8;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        wt = ((k == 1) ? 32'd2 : 32'd1)
           * ((j == 1) ? 32'd2 : 32'd1);
        sr = sr + 9'(wt * {27'd0, w[k][j][15:11]});
        sg = sg + 10'(wt * {26'd0, w[k][j][10:5]});
        sb = sb + 9'(wt * {27'd0, w[k][j][4:0]});
      end
    end
    return {sr[8:4], sg[9:4], sb[8:4]};
  endfunction

  // Top/bottom frame rows reuse the centre pixel for the missing neighbour.
  always_comb begin
    w_col    = bus.pixels_in;
    if (bus.vcount_in == 10'd0)
      w_col[0] = bus.pixels_in[1];
    if (bus.vcount_in == VLAST)
      w_col[2] = bus.pixels_in[1];
  end

  assign w_first = bus.data_valid_in
                && (bus.hcount_in == 11'd0);

  always_comb begin
    w_load = 1'b0;
    w_emit = 1'b0;
    unique case (1'b1)
      r_state == IN_ROW: begin
        w_load = bus.data_valid_in;
        w_emit = bus.data_valid_in
              && (bus.hcount_in != 11'd0);
      end
      default: w_load = w_first;
    endcase
  end

  // Flush reuses the saved row end: left=H-2, centre=right=H-1.
  always_comb begin
    w_l = r_c0;
    w_c = r_c1;
    w_r = r_c2;
    if (r_fv) begin
      w_l = r_fl_l;
      w_c = r_fl_c;
      w_r = r_fl_c;
    end
  end

  assign w_blur = blur(w_l, w_c, w_r);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= IDLE;
      r_c0    <= '0;
      r_c1    <= '0;
      r_c2    <= '0;
      r_fl_l  <= '0;
      r_fl_c  <= '0;
      r_pv    <= 1'b0;
      r_fv    <= 1'b0;
      r_ph    <= '0;
      r_pvc   <= '0;
      r_rowv  <= '0;
      r_fvc   <= '0;
      r_pix   <= '0;
      r_hout  <= '0;
      r_vout  <= '0;
      r_vld   <= 1'b0;
    end else begin
      if (w_load) begin
        r_c0   <= r_c1;
        r_c1   <= (bus.hcount_in == 11'd0) ? w_col : r_c2;
        r_c2   <= w_col;
        r_rowv <= bus.vcount_in;
      end
      r_pv <= w_emit;
      if (w_emit) begin
        r_ph  <= bus.hcount_in - 11'd1;
        r_pvc <= bus.vcount_in;
      end
      r_fv <= (r_state == FLUSH);
      if (r_state == FLUSH) begin
        r_fl_l <= r_c1;
        r_fl_c <= r_c2;
        r_fvc  <= r_rowv;
      end
      r_vld <= r_pv | r_fv;
      unique case (1'b1)
        r_fv: begin
          r_pix  <= w_blur;
          r_hout <= HLAST;
          r_vout <= r_fvc;
        end
        r_pv: begin
          r_pix  <= w_blur;
          r_hout <= r_ph;
          r_vout <= r_pvc;
        end
        default: ;
      endcase
      case (r_state)
        IDLE:
          if (w_first) r_state <= IN_ROW;
        IN_ROW:
          if (bus.data_valid_in
              && bus.hcount_in == HLAST)
            r_state <= FLUSH;
        FLUSH:
          r_state <= w_first ? IN_ROW : IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.pixel_data_out = r_pix;
  assign bus.hcount_out     = r_hout;
  assign bus.vcount_out     = r_vout;
  assign bus.data_valid_out = r_vld;
endmodule

// File: tb/tb_gauss3x3_filter.sv
// Bench for gauss3x3_filter: random rows scored against a clamped-window
// model, plus directed flat, impulse, edge, timing and reset checks.
module tb_gauss3x3_filter;
  localparam int H = 24;
  localparam int V = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gauss3x3_filter_if bus ();

  gauss3x3_filter #(.HRES(H), .VRES(V)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  typedef struct {
    int          h;
    int          v;
    logic [15:0] px;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [15:0] row [H][3];
  logic [15:0] cv  [H][3];
  logic [15:0] got [V][H];
  int          tv = -1;
  int          t_first, t_last, t_cnt;

  always @(posedge clk) cyc++;

  task automatic chk(string tag, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Blur of one output pixel: neighbours clamped to the row.
  function automatic logic [15:0] ref_px(int h);
    int sr = 0, sg = 0, sb = 0;
    for (int dh = -1; dh <= 1; dh++) begin
      int x;
      x = h + dh;
      if (x < 0) x = 0;
      if (x > H - 1) x = H - 1;
      for (int r = 0; r < 3; r++) begin
        int w;
        w = (dh == 0 ? 2 : 1) * (r == 1 ? 2 : 1);
        sr += w * int'(cv[x][r][15:11]);
        sg += w * int'(cv[x][r][10:5]);
        sb += w * int'(cv[x][r][4:0]);
      end
    end
    return {5'((sr + 8) / 16), 6'((sg + 8) / 16),
            5'((sb + 8) / 16)};
  endfunction

  task automatic send_row(int v, int n, int gap);
    int last;
    for (int h = 0; h < H; h++) begin
      cv[h][0] = (v == 0) ? row[h][1] : row[h][0];
      cv[h][1] = row[h][1];
      cv[h][2] = (v == V - 1) ? row[h][1] : row[h][2];
    end
    last = (n == H) ? H - 1 : n - 2;
    for (int h = 0; h <= last; h++)
      q.push_back('{h, v, ref_px(h)});
    for (int h = 0; h < n; h++) begin
      while ($urandom_range(99) < gap) begin
        bus.data_valid_in = 1'b0;
        bus.hcount_in = 11'($urandom_range(H - 1));
        bus.pixels_in = 48'({$urandom, $urandom});
        step();
      end
      bus.data_valid_in = 1'b1;
      bus.hcount_in = 11'(h);
      bus.vcount_in = 10'(v);
      bus.pixels_in[0] = row[h][0];
      bus.pixels_in[1] = row[h][1];
      bus.pixels_in[2] = row[h][2];
      step();
    end
    bus.data_valid_in = 1'b0;
  endtask

  task automatic rand_row();
    for (int h = 0; h < H; h++)
      for (int r = 0; r < 3; r++)
        row[h][r] = 16'($urandom);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.data_valid_out) begin
      if (q.size() == 0) begin
        chk("spurious_valid",
            32'(bus.data_valid_out), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pix", 32'(bus.pixel_data_out), 32'(e.px));
        chk("hcnt", 32'(bus.hcount_out), 32'(e.h));
        chk("vcnt", 32'(bus.vcount_out), 32'(e.v));
        got[e.v][e.h] = bus.pixel_data_out;
      end
      if (int'(bus.vcount_out) == tv) begin
        if (bus.hcount_out == 11'd0) t_first = cyc;
        if (int'(bus.hcount_out) == H - 1) t_last = cyc;
        t_cnt++;
      end
    end
  end

  initial begin
    int t0;
    bus.data_valid_in = 1'b0;
    bus.hcount_in = '0;
    bus.vcount_in = '0;
    bus.pixels_in = '0;
    repeat (3) step();
    chk("rst_valid", 32'(bus.data_valid_out), 0);
    chk("rst_pix", 32'(bus.pixel_data_out), 0);
    chk("rst_h", 32'(bus.hcount_out), 0);
    chk("rst_v", 32'(bus.vcount_out), 0);
    rst_n = 1'b1;
    step();

    // flat field, back-to-back rows
    for (int h = 0; h < H; h++)
      for (int r = 0; r < 3; r++) row[h][r] = 16'hFFFF;
    for (int v = 0; v < 3; v++) send_row(v, H, 0);
    repeat (6) step();

    // row timing
    rand_row();
    tv = 5;
    t_cnt = 0;
    t_first = -1;
    t_last = -1;
    t0 = cyc;
    send_row(5, H, 0);
    repeat (6) step();
    chk("t_first", 32'(t_first), 32'(t0 + 3));
    chk("t_last", 32'(t_last), 32'(t0 + H + 2));
    chk("t_count", 32'(t_cnt), 32'(H));
    tv = -1;

    // new row arriving in the flush cycle
    for (int v = 6; v < 9; v++) begin
      rand_row();
      send_row(v, H, 0);
    end

    // random gaps, frame edges, truncated rows
    for (int i = 0; i < 14; i++) begin
      int v, n;
      rand_row();
      v = (i == 0) ? 0 : (i == 1) ? V - 1
                        : $urandom_range(V - 1);
      n = ($urandom_range(3) == 0)
        ? $urandom_range(H - 1, 2) : H;
      send_row(v, n, 30);
      repeat ($urandom_range(3)) step();
    end
    repeat (6) step();

    // top row: missing upper neighbour replaced by centre
    for (int h = 0; h < H; h++) begin
      got[0][h] = '0;
      row[h][0] = 16'h0000;
      row[h][1] = 16'hFFFF;
      row[h][2] = 16'hFFFF;
    end
    send_row(0, H, 0);
    repeat (6) step();
    chk("top_h0", 32'(got[0][0]), 32'hFFFF);
    chk("top_h7", 32'(got[0][7]), 32'hFFFF);
    chk("top_hl", 32'(got[0][H - 1]), 32'hFFFF);

    // impulse R=16 at (10,10)
    for (int v = 8; v <= 12; v++) begin
      for (int h = 0; h < H; h++) begin
        got[v][h] = 16'hDEAD;
        for (int r = 0; r < 3; r++)
          row[h][r] = (v - 1 + r == 10 && h == 10)
                    ? 16'h8000 : 16'h0000;
      end
      send_row(v, H, 10);
    end
    repeat (6) step();
    chk("imp_c", 32'(got[10][10]), 32'h2000);
    chk("imp_n", 32'(got[9][10]), 32'h1000);
    chk("imp_s", 32'(got[11][10]), 32'h1000);
    chk("imp_w", 32'(got[10][9]), 32'h1000);
    chk("imp_e", 32'(got[10][11]), 32'h1000);
    chk("imp_nw", 32'(got[9][9]), 32'h0800);
    chk("imp_se", 32'(got[11][11]), 32'h0800);
    chk("imp_far", 32'(got[10][13]), 32'h0000);

    // reset mid-row
    rand_row();
    send_row(4, 13, 0);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(bus.data_valid_out), 0);
    chk("mrst_pix", 32'(bus.pixel_data_out), 0);
    chk("mrst_h", 32'(bus.hcount_out), 0);
    chk("mrst_v", 32'(bus.vcount_out), 0);
    q.delete();
    #2;
    rst_n = 1'b1;
    step();
    for (int h = 13; h < H; h++) begin
      bus.data_valid_in = 1'b1;
      bus.hcount_in = 11'(h);
      bus.vcount_in = 10'd4;
      step();
    end
    bus.data_valid_in = 1'b0;
    repeat (8) step();
    rand_row();
    send_row(4, H, 20);
    repeat (8) step();

    chk("q_empty", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
